pc_redirect_unit: RTL and testbench

PC_REDIRECT_UNIT -- requirements
Module: pc_redirect_unit

---
 rtl/pc_redirect_unit.sv | 152 +++++++++++++++
 tb/tb_pc_redirect_unit.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/pc_redirect_unit.sv
// Resolves BRANCH/CALL/RET into a redirect PC with a circular return-address stack.
// One-cycle latency; holds the response until resp_ready and accepts no request meanwhile.
module pc_redirect_unit #(
  parameter int PC_W      = 16,
  parameter int TGT_W     = 12,
  parameter int OFS_W     = 16,
  parameter int RAS_DEPTH = 8
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           req_valid,
  output logic                           req_ready,
  input  logic [1:0]                     req_op,
  input  logic [2:0]                     branch_cond,
  input  logic [2:0]                     flags,
  input  logic [PC_W-1:0]                pc_in,
  input  logic [OFS_W-1:0]               sign_ext,
  input  logic [TGT_W-1:0]               call_target,
  input  logic [PC_W-1:0]                ret_fallback_pc,
  output logic                           resp_valid,
  input  logic                           resp_ready,
  output logic                           resp_taken,
  output logic [PC_W-1:0]                resp_pc,
  input  logic                           flush,
  input  logic                           err_clr,
  output logic                           ras_overflow,
  output logic                           ras_underflow,
  output logic [$clog2(RAS_DEPTH):0]     ras_count
);

  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {IDLE, RESP} state_e;

  state_e           state_q, state_d;
  logic [PC_W-1:0]  ras_q [RAS_DEPTH];
  logic [PTR_W-1:0] sp_q, sp_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             taken_q, taken_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic             ovf_q, ovf_d, unf_q, unf_d;
  logic             push, pop, cond, accept;
  logic             z, v, n;
  logic [PC_W-1:0]  ofs_ext, pc_inc;

  assign {z, v, n} = flags;
  assign ofs_ext   = PC_W'($signed(sign_ext));
  assign pc_inc    = pc_in + PC_W'(1);
  assign accept    = req_valid && (state_q == IDLE) && !flush;

  always_comb begin
    cond = 1'b0;
    case (branch_cond)
      3'b000:  cond = z;
      3'b001:  cond = n & ~v;
      3'b010:  cond = ~z & ~n & ~v;
      3'b011:  cond = v;
      3'b100:  cond = ~z;
      3'b101:  cond = v | ~n;
      3'b110:  cond = z | (n & ~v);
      default: cond = 1'b1;
    endcase
  end

  always_comb begin
    state_d = state_q;
    taken_d = taken_q;
    pc_d    = pc_q;
    sp_d    = sp_q;
    cnt_d   = cnt_q;
    push    = 1'b0;
    pop     = 1'b0;
    ovf_d   = ovf_q & ~err_clr;
    unf_d   = unf_q & ~err_clr;

    if (flush) begin
      state_d = IDLE;
    end else if (state_q == RESP) begin
      if (resp_ready) state_d = IDLE;
    end else if (accept) begin
      case (req_op)
        2'b01: begin
          state_d = RESP;
          taken_d = cond;
          pc_d    = cond ? pc_in + ofs_ext : pc_inc;
        end
        2'b10: begin
          state_d = RESP;
          taken_d = 1'b1;
          pc_d    = {pc_in[PC_W-1:TGT_W], call_target};
          push    = 1'b1;
        end
        2'b11: begin
          state_d = RESP;
          taken_d = 1'b1;
          if (cnt_q != '0) begin
            pc_d = ras_q[sp_q - PTR_W'(1)];
            pop  = 1'b1;
          end else begin
            pc_d  = ret_fallback_pc;
            unf_d = 1'b1;
          end
        end
        default: ;
      endcase
    end

    // A push at full lands on the oldest slot because sp has wrapped onto it.
    if (push) begin
      sp_d = sp_q + PTR_W'(1);
      if (cnt_q == CNT_W'(RAS_DEPTH)) ovf_d = 1'b1;
      else                            cnt_d = cnt_q + CNT_W'(1);
    end else if (pop) begin
      sp_d  = sp_q - PTR_W'(1);
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      taken_q <= 1'b0;
      pc_q    <= '0;
      sp_q    <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      taken_q <= taken_d;
      pc_q    <= pc_d;
      sp_q    <= sp_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && push) ras_q[sp_q] <= pc_inc;
  end

  assign req_ready     = (state_q == IDLE);
  assign resp_valid    = (state_q == RESP);
  assign resp_taken    = taken_q;
  assign resp_pc       = pc_q;
  assign ras_overflow  = ovf_q;
  assign ras_underflow = unf_q;
  assign ras_count     = cnt_q;

endmodule

// File: tb/tb_pc_redirect_unit.sv
// Randomized and directed bench for pc_redirect_unit against a queue-based reference model.
module tb_pc_redirect_unit;

  localparam int PC_W = 16, TGT_W = 12, OFS_W = 16, RAS_DEPTH = 8;
  localparam logic [1:0] NOP = 2'b00, BRANCH = 2'b01, CALL = 2'b10, RET = 2'b11;

  logic              clk = 1'b0;
  logic              rst_n, req_valid, req_ready, resp_valid, resp_ready, resp_taken;
  logic [1:0]        req_op;
  logic [2:0]        branch_cond, flags;
  logic [PC_W-1:0]   pc_in, ret_fallback_pc, resp_pc;
  logic [OFS_W-1:0]  sign_ext;
  logic [TGT_W-1:0]  call_target;
  logic              flush, err_clr, ras_overflow, ras_underflow;
  logic [3:0]        ras_count;

  int n_checks = 0;
  int n_errors = 0;

  // reference model state
  bit              m_pend, m_taken, m_ovf, m_unf;
  logic [15:0]     m_pc;
  logic [15:0]     m_ras[$];

  always #5 clk = ~clk;

  pc_redirect_unit #(.PC_W(PC_W), .TGT_W(TGT_W), .OFS_W(OFS_W), .RAS_DEPTH(RAS_DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .branch_cond(branch_cond), .flags(flags), .pc_in(pc_in), .sign_ext(sign_ext),
    .call_target(call_target), .ret_fallback_pc(ret_fallback_pc), .resp_valid(resp_valid),
    .resp_ready(resp_ready), .resp_taken(resp_taken), .resp_pc(resp_pc), .flush(flush),
    .err_clr(err_clr), .ras_overflow(ras_overflow), .ras_underflow(ras_underflow),
    .ras_count(ras_count)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit taken_rule(input logic [2:0] c, input logic [2:0] f);
    bit z, v, n;
    z = f[2]; v = f[1]; n = f[0];
    case (c)
      3'd0: return z;
      3'd1: return n && !v;
      3'd2: return !z && !n && !v;
      3'd3: return v;
      3'd4: return !z;
      3'd5: return v || !n;
      3'd6: return z || (n && !v);
      default: return 1'b1;
    endcase
  endfunction

  task automatic model_step();
    bit set_ovf, set_unf;
    int off;
    set_ovf = 0; set_unf = 0;
    if (!rst_n) begin
      m_pend = 0; m_taken = 0; m_pc = 0; m_ovf = 0; m_unf = 0;
      m_ras.delete();
      return;
    end
    if (flush) m_pend = 0;
    else if (m_pend) begin
      if (resp_ready) m_pend = 0;
    end else if (req_valid && req_op != NOP) begin
      m_pend = 1;
      if (req_op == BRANCH) begin
        m_taken = taken_rule(branch_cond, flags);
        off = $signed(sign_ext);
        m_pc = m_taken ? 16'(int'(pc_in) + off) : 16'(int'(pc_in) + 1);
      end else if (req_op == CALL) begin
        m_taken = 1;
        m_pc = (pc_in & 16'hF000) | 16'(call_target);
        if (m_ras.size() == RAS_DEPTH) begin
          void'(m_ras.pop_front());
          set_ovf = 1;
        end
        m_ras.push_back(16'(int'(pc_in) + 1));
      end else begin
        m_taken = 1;
        if (m_ras.size() > 0) m_pc = m_ras.pop_back();
        else begin
          m_pc = ret_fallback_pc;
          set_unf = 1;
        end
      end
    end
    m_ovf = set_ovf ? 1'b1 : (err_clr ? 1'b0 : m_ovf);
    m_unf = set_unf ? 1'b1 : (err_clr ? 1'b0 : m_unf);
  endtask

  task automatic compare_all();
    check_eq("resp_valid", resp_valid, m_pend);
    check_eq("req_ready", req_ready, !m_pend);
    check_eq("ras_count", ras_count, m_ras.size());
    check_eq("ras_overflow", ras_overflow, m_ovf);
    check_eq("ras_underflow", ras_underflow, m_unf);
    if (m_pend) begin
      check_eq("resp_taken", resp_taken, m_taken);
      check_eq("resp_pc", resp_pc, m_pc);
    end
  endtask

  // Inputs are set at the falling edge; the model advances with them, then DUT is compared.
  task automatic step();
    model_step();
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  task automatic quiet();
    rst_n = 1; req_valid = 0; req_op = NOP; branch_cond = 0; flags = 0; pc_in = 0;
    sign_ext = 0; call_target = 0; ret_fallback_pc = 16'hBEEF; resp_ready = 1;
    flush = 0; err_clr = 0;
  endtask

  task automatic issue(input logic [1:0] op, input logic [15:0] pc);
    quiet();
    req_valid = 1; req_op = op; pc_in = pc; resp_ready = 0;
    step();
  endtask

  initial begin
    quiet();
    rst_n = 0;
    @(negedge clk);
    step();
    check_eq("rst_pc", resp_pc, 16'h0000);
    check_eq("rst_taken", resp_taken, 1'b0);
    check_eq("rst_count", ras_count, 4'd0);

    // taken EQ branch wrapping backwards to zero
    quiet(); req_valid = 1; req_op = BRANCH; branch_cond = 3'd0; flags = 3'b100;
    pc_in = 16'h0010; sign_ext = 16'hFFF0; resp_ready = 0;
    step();
    check_eq("beq_valid", resp_valid, 1'b1);
    check_eq("beq_taken", resp_taken, 1'b1);
    check_eq("beq_pc", resp_pc, 16'h0000);
    quiet(); step();

    // not-taken GT, response held under backpressure
    quiet(); req_valid = 1; req_op = BRANCH; branch_cond = 3'd2; flags = 3'b001;
    pc_in = 16'h0020; sign_ext = 16'h0100; resp_ready = 0;
    step();
    for (int i = 0; i < 3; i++) begin
      req_op = CALL; pc_in = 16'h7777;
      check_eq("bgt_hold_taken", resp_taken, 1'b0);
      check_eq("bgt_hold_pc", resp_pc, 16'h0021);
      check_eq("bgt_hold_ready", req_ready, 1'b0);
      step();
    end
    quiet(); step();

    // CALL then RET
    quiet(); req_valid = 1; req_op = CALL; pc_in = 16'hA123; call_target = 12'h456; resp_ready = 0;
    step();
    check_eq("call_pc", resp_pc, 16'hA456);
    check_eq("call_cnt", ras_count, 4'd1);
    quiet(); step();
    issue(RET, 16'h0000);
    check_eq("ret_pc", resp_pc, 16'hA124);
    check_eq("ret_cnt", ras_count, 4'd0);
    quiet(); step();

    // overflow with nine CALLs, then drain and underflow
    for (int i = 0; i < 9; i++) begin
      issue(CALL, 16'(i));
      quiet(); step();
    end
    check_eq("ovf_flag", ras_overflow, 1'b1);
    check_eq("ovf_cnt", ras_count, 4'd8);
    for (int i = 0; i < 8; i++) begin
      issue(RET, 16'h0000);
      check_eq("drain_pc", resp_pc, 16'(9 - i));
      quiet(); step();
    end
    issue(RET, 16'h0000);
    check_eq("unf_pc", resp_pc, 16'hBEEF);
    check_eq("unf_flag", ras_underflow, 1'b1);
    quiet(); err_clr = 1; step();
    check_eq("clr_ovf", ras_overflow, 1'b0);
    check_eq("clr_unf", ras_underflow, 1'b0);

    // flush after CALL keeps the push
    issue(CALL, 16'h0300);
    quiet(); flush = 1; resp_ready = 0; step();
    check_eq("flush_valid", resp_valid, 1'b0);
    check_eq("flush_cnt", ras_count, 4'd1);

    // reset during a pending response
    issue(CALL, 16'h0400);
    quiet(); rst_n = 0; resp_ready = 0; step();
    check_eq("rst_resp_valid", resp_valid, 1'b0);
    check_eq("rst_resp_pc", resp_pc, 16'h0000);
    check_eq("rst_resp_ready", req_ready, 1'b1);
    check_eq("rst_resp_cnt", ras_count, 4'd0);

    for (int i = 0; i < 3000; i++) begin
      quiet();
      rst_n           = ($urandom_range(0, 199) != 0);
      req_valid       = ($urandom_range(0, 9) < 7);
      req_op          = 2'($urandom());
      branch_cond     = 3'($urandom());
      flags           = 3'($urandom());
      pc_in           = 16'($urandom());
      sign_ext        = 16'($urandom());
      call_target     = 12'($urandom());
      ret_fallback_pc = 16'($urandom());
      resp_ready      = ($urandom_range(0, 9) < 6);
      flush           = ($urandom_range(0, 19) == 0);
      err_clr         = ($urandom_range(0, 19) == 0);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
